// File: rtl/axisr_pkt_tx.sv
// Framing transmitter: turns (length, tid) descriptors plus raw payload beats into AXI4SR packets.
// Optional AXISR_TX_STATS_EN macro enables the packet/beat statistics counters.
module axisr_pkt_tx #(
    parameter int unsigned DATA_BITS = 512,
    parameter int unsigned ID_BITS   = 6,
    parameter int unsigned LEN_BITS  = 28
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_req_valid,
    output logic                   s_req_ready,
    input  logic [LEN_BITS-1:0]    s_req_len,
    input  logic [ID_BITS-1:0]     s_req_tid,
    input  logic                   s_data_tvalid,
    output logic                   s_data_tready,
    input  logic [DATA_BITS-1:0]   s_data_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [ID_BITS-1:0]     m_axis_tid,
    output logic [31:0]            stat_pkts,
    output logic [31:0]            stat_beats
);

    localparam int unsigned KEEP_BITS = DATA_BITS / 8;
    localparam int unsigned LOG2B     = $clog2(KEEP_BITS);
    localparam int unsigned CNT_BITS  = LEN_BITS - LOG2B + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DROP   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   req_ready_d;
    logic [CNT_BITS-1:0]    cnt_q;
    logic [KEEP_BITS-1:0]   last_keep_q;
    logic [ID_BITS-1:0]     tid_q;
    logic [CNT_BITS-1:0]    req_beats;
    logic [LOG2B-1:0]       req_rem;
    logic [KEEP_BITS-1:0]   req_keep;
    logic                   req_hs;
    logic                   data_hs;
    logic                   last_beat;

    assign req_hs    = s_req_valid && s_req_ready;
    assign data_hs   = s_data_tvalid && s_data_tready;
    assign last_beat = (cnt_q == CNT_BITS'(1));

    // Payload may only advance when the output register is free or draining this cycle
    assign s_data_tready = (state_q == S_STREAM) && (!m_axis_tvalid || m_axis_tready);

    // ceil(len/B) and the partial-beat keep mask
    assign req_rem   = s_req_len[LOG2B-1:0];
    assign req_beats = CNT_BITS'(s_req_len[LEN_BITS-1:LOG2B]) + CNT_BITS'(|req_rem);

    always_comb begin
        req_keep = '1;
        for (int i = 0; i < int'(KEEP_BITS); i++) begin
            if (req_rem != '0) begin
                req_keep[i] = (LOG2B'(i) < req_rem);
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= S_IDLE;
            s_req_ready <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_req_ready <= req_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_hs) begin
                    state_d = (s_req_len == '0) ? S_DROP : S_STREAM;
                end
            end
            S_STREAM: begin
                if (data_hs && last_beat) begin
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    // Descriptor latch and output register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_q         <= '0;
            last_keep_q   <= '0;
            tid_q         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
        end else begin
            if (req_hs) begin
                cnt_q       <= req_beats;
                last_keep_q <= req_keep;
                tid_q       <= s_req_tid;
            end
            if (data_hs) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_data_tdata;
                m_axis_tkeep  <= last_beat ? last_keep_q : '1;
                m_axis_tlast  <= last_beat;
                m_axis_tid    <= tid_q;
                cnt_q         <= cnt_q - CNT_BITS'(1);
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef AXISR_TX_STATS_EN
    logic out_hs;
    assign out_hs = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stat_pkts  <= '0;
            stat_beats <= '0;
        end else if (out_hs) begin
            stat_beats <= stat_beats + 32'd1;
            if (m_axis_tlast) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
        end
    end
`else
    assign stat_pkts  = '0;
    assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_axisr_pkt_tx.sv
// Directed bench for axisr_pkt_tx (512-bit data), checked with immediate assertions.
module tb_axisr_pkt_tx;

    localparam int unsigned DATA_BITS = 512;
    localparam int unsigned ID_BITS   = 6;
    localparam int unsigned LEN_BITS  = 28;
    localparam int unsigned KEEP_BITS = DATA_BITS / 8;

    logic                  aclk = 1'b0;
    logic                  areset;
    logic                  s_req_valid;
    logic                  s_req_ready;
    logic [LEN_BITS-1:0]   s_req_len;
    logic [ID_BITS-1:0]    s_req_tid;
    logic                  s_data_tvalid;
    logic                  s_data_tready;
    logic [DATA_BITS-1:0]  s_data_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [DATA_BITS-1:0]  m_axis_tdata;
    logic [KEEP_BITS-1:0]  m_axis_tkeep;
    logic                  m_axis_tlast;
    logic [ID_BITS-1:0]    m_axis_tid;
    logic [31:0]           stat_pkts;
    logic [31:0]           stat_beats;

    int checks = 0;
    int errors = 0;

    axisr_pkt_tx #(
        .DATA_BITS(DATA_BITS),
        .ID_BITS  (ID_BITS),
        .LEN_BITS (LEN_BITS)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_req_valid  (s_req_valid),
        .s_req_ready  (s_req_ready),
        .s_req_len    (s_req_len),
        .s_req_tid    (s_req_tid),
        .s_data_tvalid(s_data_tvalid),
        .s_data_tready(s_data_tready),
        .s_data_tdata (s_data_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tid   (m_axis_tid),
        .stat_pkts    (stat_pkts),
        .stat_beats   (stat_beats)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [DATA_BITS-1:0] obs, input logic [DATA_BITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a descriptor; returns at the falling edge after the accepting rising edge
    task automatic send_req(input logic [LEN_BITS-1:0] len, input logic [ID_BITS-1:0] tid);
        int n;
        s_req_valid = 1'b1;
        s_req_len   = len;
        s_req_tid   = tid;
        n = 0;
        while (!s_req_ready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("req_accept_timeout", DATA_BITS'(n < 20), DATA_BITS'(1));
        @(negedge aclk);
        s_req_valid = 1'b0;
    endtask

    // Offer one payload beat; returns at the falling edge after it was taken
    task automatic send_beat(input logic [DATA_BITS-1:0] data);
        int n;
        s_data_tvalid = 1'b1;
        s_data_tdata  = data;
        #1;
        n = 0;
        while (!s_data_tready && n < 20) begin
            @(negedge aclk);
            #1;
            n++;
        end
        check("beat_accept_timeout", DATA_BITS'(n < 20), DATA_BITS'(1));
        @(negedge aclk);
        s_data_tvalid = 1'b0;
    endtask

    task automatic check_beat(input string tag, input logic [DATA_BITS-1:0] data,
                              input logic [KEEP_BITS-1:0] keep, input logic last,
                              input logic [ID_BITS-1:0] tid);
        check({tag, "_tvalid"}, DATA_BITS'(m_axis_tvalid), DATA_BITS'(1));
        check({tag, "_tdata"},  m_axis_tdata, data);
        check({tag, "_tkeep"},  DATA_BITS'(m_axis_tkeep), DATA_BITS'(keep));
        check({tag, "_tlast"},  DATA_BITS'(m_axis_tlast), DATA_BITS'(last));
        check({tag, "_tid"},    DATA_BITS'(m_axis_tid), DATA_BITS'(tid));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [KEEP_BITS-1:0] keep_all;
        logic [DATA_BITS-1:0] beat [4];
        logic [DATA_BITS-1:0] held_data;
        logic                 held_last;
        logic                 stall_prev;
        logic                 stall_now;
        logic [3:0]           rdy_pat;
        int                   sent;
        int                   recv;
        int                   cyc;

        keep_all = '1;
        rdy_pat  = 4'b1001;  // bit k = tready in cycle k mod 4 (1,0,0,1)

        areset        = 1'b1;
        s_req_valid   = 1'b0;
        s_req_len     = '0;
        s_req_tid     = '0;
        s_data_tvalid = 1'b0;
        s_data_tdata  = '0;
        m_axis_tready = 1'b1;

        // Reset state
        repeat (2) @(negedge aclk);
        check("rst_req_ready",  DATA_BITS'(s_req_ready), '0);
        check("rst_data_tready", DATA_BITS'(s_data_tready), '0);
        check("rst_tvalid",     DATA_BITS'(m_axis_tvalid), '0);
        check("rst_tdata",      m_axis_tdata, '0);
        check("rst_tkeep",      DATA_BITS'(m_axis_tkeep), '0);
        check("rst_tlast",      DATA_BITS'(m_axis_tlast), '0);
        check("rst_tid",        DATA_BITS'(m_axis_tid), '0);
        check("rst_stat_pkts",  DATA_BITS'(stat_pkts), '0);
        check("rst_stat_beats", DATA_BITS'(stat_beats), '0);
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_req_ready", DATA_BITS'(s_req_ready), DATA_BITS'(1));

        // Single full beat: len=64, tid=3
        send_req(28'd64, 6'd3);
        check("t1_data_tready", DATA_BITS'(s_data_tready), DATA_BITS'(1));
        check("t1_no_early_out", DATA_BITS'(m_axis_tvalid), '0);
        beat[0] = {16{32'h1111_0001}};
        send_beat(beat[0]);
        check_beat("t1_b0", beat[0], keep_all, 1'b1, 6'd3);
        check("t1_req_ready_back", DATA_BITS'(s_req_ready), DATA_BITS'(1));
        @(negedge aclk);
        check("t1_drained", DATA_BITS'(m_axis_tvalid), '0);

        // len=130, tid=5: three beats, last keep 0x3
        send_req(28'd130, 6'd5);
        for (int b = 0; b < 3; b++) begin
            beat[b] = {16{32'h2222_0000 + 32'(b)}};
            send_beat(beat[b]);
            check_beat($sformatf("t2_b%0d", b), beat[b],
                       (b == 2) ? KEEP_BITS'(64'h3) : keep_all, (b == 2), 6'd5);
        end
        @(negedge aclk);

        // len=256, tid=9, tready pattern 1,0,0,1 repeating
        send_req(28'd256, 6'd9);
        for (int b = 0; b < 4; b++) beat[b] = {16{32'h3333_0000 + 32'(b)}};
        sent       = 0;
        recv       = 0;
        cyc        = 0;
        stall_prev = 1'b0;
        held_data  = '0;
        held_last  = 1'b0;
        while (recv < 4 && cyc < 60) begin
            m_axis_tready = rdy_pat[cyc % 4];
            s_data_tvalid = (sent < 4);
            s_data_tdata  = (sent < 4) ? beat[sent] : '0;
            #1;
            if (stall_prev) begin
                check("t3_hold_tdata", m_axis_tdata, held_data);
                check("t3_hold_tlast", DATA_BITS'(m_axis_tlast), DATA_BITS'(held_last));
            end
            stall_now = m_axis_tvalid && !m_axis_tready;
            if (stall_now) begin
                check("t3_stall_data_tready", DATA_BITS'(s_data_tready), '0);
                held_data = m_axis_tdata;
                held_last = m_axis_tlast;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check_beat($sformatf("t3_b%0d", recv), beat[recv], keep_all, (recv == 3), 6'd9);
                recv++;
            end
            if (s_data_tvalid && s_data_tready) sent++;
            stall_prev = stall_now;
            @(negedge aclk);
            cyc++;
        end
        check("t3_beats_received", DATA_BITS'(recv), DATA_BITS'(4));
        s_data_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge aclk);

        // Zero-length descriptor followed by a one-byte packet
        send_req(28'd0, 6'd1);
        check("t4_req_ready_low", DATA_BITS'(s_req_ready), '0);
        check("t4_data_tready", DATA_BITS'(s_data_tready), '0);
        check("t4_tvalid_a", DATA_BITS'(m_axis_tvalid), '0);
        @(negedge aclk);
        check("t4_req_ready_back", DATA_BITS'(s_req_ready), DATA_BITS'(1));
        check("t4_tvalid_b", DATA_BITS'(m_axis_tvalid), '0);
        send_req(28'd1, 6'd2);
        beat[0] = {16{32'h4444_0001}};
        send_beat(beat[0]);
        check_beat("t4_b0", beat[0], KEEP_BITS'(64'h1), 1'b1, 6'd2);
        @(negedge aclk);

        // Reset after beat 2 of a 4-beat packet
        send_req(28'd256, 6'd7);
        for (int b = 0; b < 2; b++) begin
            beat[b] = {16{32'h5555_0000 + 32'(b)}};
            send_beat(beat[b]);
        end
        check_beat("t5_b1", beat[1], keep_all, 1'b0, 6'd7);
        areset = 1'b1;
        #1;
        check("t5_rst_tvalid", DATA_BITS'(m_axis_tvalid), '0);
        check("t5_rst_tdata", m_axis_tdata, '0);
        check("t5_rst_req_ready", DATA_BITS'(s_req_ready), '0);
        check("t5_rst_data_tready", DATA_BITS'(s_data_tready), '0);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check("t5_req_ready_back", DATA_BITS'(s_req_ready), DATA_BITS'(1));
        send_req(28'd64, 6'd4);
        beat[0] = {16{32'h5555_00AA}};
        send_beat(beat[0]);
        check_beat("t5_new", beat[0], keep_all, 1'b1, 6'd4);
        @(negedge aclk);

        // Statistics: fresh reset, then 4 packets of 100 bytes (2 beats each)
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        for (int p = 0; p < 4; p++) begin
            send_req(28'd100, 6'(p + 10));
            for (int b = 0; b < 2; b++) begin
                beat[b] = {16{32'h6600_0000 + 32'(p * 16 + b)}};
                send_beat(beat[b]);
                if (p == 0) begin
                    check_beat($sformatf("t6_b%0d", b), beat[b],
                               (b == 1) ? KEEP_BITS'(64'hF_FFFF_FFFF) : keep_all, (b == 1), 6'd10);
                end
            end
        end
        @(negedge aclk);
        check("t6_idle", DATA_BITS'(m_axis_tvalid), '0);
`ifdef AXISR_TX_STATS_EN
        check("t6_stat_pkts",  DATA_BITS'(stat_pkts),  DATA_BITS'(4));
        check("t6_stat_beats", DATA_BITS'(stat_beats), DATA_BITS'(8));
`else
        check("t6_stat_pkts",  DATA_BITS'(stat_pkts),  '0);
        check("t6_stat_beats", DATA_BITS'(stat_beats), '0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
